// File: rtl/alu_bm_pkg.sv
// alu_bm_pkg: op codes, control layout, clmul FSM state and clmul step helper
package alu_bm_pkg;
  localparam int CTL_OP_LSB = 0;
  localparam int CTL_OP_MSB = 3;
  localparam int CTL_WORD = 4;
  typedef enum logic [3:0] {
    OP_CLZ, OP_CTZ, OP_CPOP, OP_ROL, OP_ROR, OP_ORCB, OP_REV8, OP_MIN,
    OP_MINU, OP_MAX, OP_MAXU, OP_ANDN, OP_CLMUL, OP_CLMULH, OP_CLMULR, OP_RSVD
  } bm_op_e;
  typedef enum logic {S_IDLE, S_RUN} bm_state_e;
  // Sized for the widest datapath; callers zero-extend and truncate.
  function automatic logic [127:0] clmul_step(input logic [127:0] acc, input logic [63:0] a,
                                              input logic [63:0] chunk, input int nbits, input int base);
    logic [127:0] r;
    r = acc;
    for (int j = 0; j < 64; j++)
      if (j < nbits && chunk[j]) r = r ^ ({64'b0, a} << (base + j));
    return r;
  endfunction
endpackage

// File: rtl/alu_bm_count.sv
// alu_bm_count: combinational clz/ctz/cpop, word mode counts over the low 32 bits
module alu_bm_count #(
  parameter int RV = 64,
  localparam int CW = $clog2(RV) + 1
) (
  input  logic [RV-1:0] a,
  input  logic          word,
  output logic [CW-1:0] clz,
  output logic [CW-1:0] ctz,
  output logic [CW-1:0] cpop
);
  int n;
  logic hl, ht;
  always_comb begin
    n = word ? 32 : RV;
    clz = '0;
    ctz = '0;
    cpop = '0;
    hl = 1'b0;
    ht = 1'b0;
    for (int i = RV - 1; i >= 0; i--)
      if (i < n) begin
        hl = hl | a[i];
        clz = clz + CW'(!hl);
      end
    for (int i = 0; i < RV; i++)
      if (i < n) begin
        ht = ht | a[i];
        ctz = ctz + CW'(!ht);
        cpop = cpop + CW'(a[i]);
      end
  end
endmodule

// File: rtl/alu_bitmanip_seq.sv
// alu_bitmanip_seq: single-cycle Zbb ops plus iterative Zbc clmul with commit-slot kill
module alu_bitmanip_seq
  import alu_bm_pkg::*;
#(
  parameter int RV = 64,
  parameter int NHART = 1,
  parameter int LNHART = 0,
  parameter int NCOMMIT = 32,
  parameter int LNCOMMIT = 5,
  parameter int CLMUL_BITS = 8,
  localparam int HW = (LNHART > 0) ? LNHART : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [4:0]          control,
  input  logic [LNCOMMIT-1:0] rd,
  input  logic                makes_rd,
  input  logic [HW-1:0]       hart,
  input  logic                rv32,
  input  logic [RV-1:0]       r1,
  input  logic [RV-1:0]       r2,
  input  logic [NCOMMIT-1:0]  commit_kill,
  output logic                busy,
  output logic [RV-1:0]       result,
  output logic [LNCOMMIT-1:0] res_rd,
  output logic [NHART-1:0]    res_makes_rd
);
  localparam int NSTEP = RV / CLMUL_BITS;
  localparam int SW = ($clog2(NSTEP) > 0) ? $clog2(NSTEP) : 1;
  localparam int AW = $clog2(RV);
  localparam int CW = AW + 1;
  bm_state_e state, state_nx;
  bm_op_e op, op_q;
  logic word, is_clm, accept, kill_run, last, done, mrd_q;
  logic [RV-1:0] a_q, b_q, one_res, clm_res, orc, rev;
  logic [2*RV-1:0] acc_q, acc_nx, rl, rr;
  logic [127:0] step_full;
  logic [63:0] rlw, rrw;
  logic [CLMUL_BITS-1:0] chunk;
  logic [SW-1:0] step;
  logic [LNCOMMIT-1:0] rd_q;
  logic [HW-1:0] hart_q;
  logic [CW-1:0] clz_c, ctz_c, pop_c;
  assign op = bm_op_e'(control[CTL_OP_MSB:CTL_OP_LSB]);
  assign word = control[CTL_WORD] | rv32;
  assign is_clm = op inside {OP_CLMUL, OP_CLMULH, OP_CLMULR};
  assign accept = enable && !busy && !commit_kill[rd];
  assign kill_run = state == S_RUN && commit_kill[rd_q];
  assign last = step == SW'(NSTEP - 1);
  assign done = state == S_RUN && last && !kill_run;
  alu_bm_count #(.RV(RV)) u_count (
    .a(r1), .word(word), .clz(clz_c), .ctz(ctz_c), .cpop(pop_c)
  );
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    if (state == S_IDLE) state_nx = (accept && is_clm) ? S_RUN : S_IDLE;
    else state_nx = (kill_run || last) ? S_IDLE : S_RUN;
  end
  always_comb busy = state == S_RUN;
  assign chunk = b_q[int'(step)*CLMUL_BITS +: CLMUL_BITS];
  assign step_full = clmul_step(128'(acc_q), 64'(a_q), 64'(chunk), CLMUL_BITS, int'(step) * CLMUL_BITS);
  assign acc_nx = step_full[2*RV-1:0];
  assign clm_res = op_q == OP_CLMUL  ? acc_nx[RV-1:0] :
                   op_q == OP_CLMULH ? acc_nx[2*RV-1:RV] : acc_nx[2*RV-2:RV-1];
  always_comb begin
    rl = {r1, r1} << r2[AW-1:0];
    rr = {r1, r1} >> r2[AW-1:0];
    rlw = {r1[31:0], r1[31:0]} << r2[4:0];
    rrw = {r1[31:0], r1[31:0]} >> r2[4:0];
    orc = '0;
    rev = '0;
    for (int i = 0; i < RV / 8; i++) begin
      orc[8*i +: 8] = {8{|r1[8*i +: 8]}};
      rev[8*i +: 8] = r1[RV-8-8*i +: 8];
    end
    case (op)
      OP_CLZ:  one_res = RV'(clz_c);
      OP_CTZ:  one_res = RV'(ctz_c);
      OP_CPOP: one_res = RV'(pop_c);
      OP_ROL:  one_res = word ? RV'($signed(rlw[63:32])) : rl[2*RV-1:RV];
      OP_ROR:  one_res = word ? RV'($signed(rrw[31:0])) : rr[RV-1:0];
      OP_ORCB: one_res = orc;
      OP_REV8: one_res = rev;
      OP_MIN:  one_res = $signed(r1) < $signed(r2) ? r1 : r2;
      OP_MINU: one_res = r1 < r2 ? r1 : r2;
      OP_MAX:  one_res = $signed(r1) < $signed(r2) ? r2 : r1;
      OP_MAXU: one_res = r1 < r2 ? r2 : r1;
      OP_ANDN: one_res = r1 & ~r2;
      default: one_res = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      step <= '0;
      rd_q <= '0;
      hart_q <= '0;
      mrd_q <= 1'b0;
      op_q <= OP_RSVD;
      result <= '0;
      res_rd <= '0;
      res_makes_rd <= '0;
    end else begin
      res_makes_rd <= '0;
      if (accept) begin
        a_q <= r1;
        b_q <= r2;
        rd_q <= rd;
        hart_q <= hart;
        mrd_q <= makes_rd;
        op_q <= op;
        acc_q <= '0;
        step <= '0;
        if (!is_clm && makes_rd) begin
          result <= one_res;
          res_rd <= rd;
          res_makes_rd <= NHART'(1) << hart;
        end
      end else if (state == S_RUN) begin
        acc_q <= acc_nx;
        step <= step + SW'(1);
        if (done && mrd_q) begin
          result <= clm_res;
          res_rd <= rd_q;
          res_makes_rd <= NHART'(1) << hart_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_bitmanip_seq.sv
// tb_alu_bitmanip_seq: directed vectors for single-cycle ops, clmul timing, kill and reset
module tb_alu_bitmanip_seq;
  import alu_bm_pkg::*;
  logic clk = 1'b0;
  logic reset, enable, makes_rd, rv32, busy;
  logic [4:0] control, rd, res_rd;
  logic [0:0] hart, res_makes_rd;
  logic [63:0] r1, r2, result;
  logic [31:0] commit_kill;
  int checks = 0, failures = 0;
  typedef struct {logic [4:0] c; logic [63:0] a, b, e;} vec_t;
  always #5 clk = ~clk;
  alu_bitmanip_seq dut (
    .clk(clk), .reset(reset), .enable(enable), .control(control), .rd(rd),
    .makes_rd(makes_rd), .hart(hart), .rv32(rv32), .r1(r1), .r2(r2),
    .commit_kill(commit_kill), .busy(busy), .result(result), .res_rd(res_rd),
    .res_makes_rd(res_makes_rd)
  );
  always @(negedge clk)
    if (enable && busy) begin
      failures++;
      $display("FAIL issue_while_busy enable=%b busy=%b required no issue while busy", enable, busy);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] c, input logic [4:0] d, input logic [63:0] a, input logic [63:0] b);
    enable = 1'b1;
    control = c;
    rd = d;
    r1 = a;
    r2 = b;
  endtask
  task automatic run_table(input string name, input vec_t v[]);
    foreach (v[i]) begin
      drive(v[i].c, 5'(i + 1), v[i].a, v[i].b);
      tick();
      enable = 1'b0;
      checks++;
      if (result !== v[i].e || res_makes_rd !== 1'b1 || res_rd !== 5'(i + 1)) begin
        failures++;
        $display("FAIL %s[%0d] result=%h rd=%0d we=%b required result=%h rd=%0d we=1",
                 name, i, result, res_rd, res_makes_rd, v[i].e, i + 1);
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || result !== 64'h0 || res_rd !== 5'h0 || res_makes_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset busy=%b result=%h rd=%0d we=%b required all zero", busy, result, res_rd, res_makes_rd);
    end
    reset = 1'b0;
    tick();
  endtask
  task automatic test_count();
    vec_t v[];
    v = '{'{{1'b0, OP_CLZ}, 64'h0F00, 64'h0, 64'd52},
          '{{1'b1, OP_CLZ}, 64'hFFFF_FFFF_0000_F000, 64'h0, 64'd16},
          '{{1'b0, OP_CLZ}, 64'h0, 64'h0, 64'd64},
          '{{1'b1, OP_CTZ}, 64'h0, 64'h0, 64'd32},
          '{{1'b0, OP_CTZ}, 64'h0000_0100_0000_0000, 64'h0, 64'd40},
          '{{1'b0, OP_CPOP}, 64'hFF00_0000_0000_0001, 64'h0, 64'd9},
          '{{1'b1, OP_CPOP}, 64'hFF00_0000_0000_0001, 64'h0, 64'd1}};
    run_table("count", v);
    tick();
    checks++;
    if (res_makes_rd !== 1'b0 || result !== 64'd1) begin
      failures++;
      $display("FAIL hold we=%b result=%h required we=0 result=1", res_makes_rd, result);
    end
    rv32 = 1'b1;
    drive({1'b0, OP_CLZ}, 5'd12, 64'hF000_0000_0000_F000, 64'h0);
    tick();
    enable = 1'b0;
    rv32 = 1'b0;
    checks++;
    if (result !== 64'd16 || res_makes_rd !== 1'b1) begin
      failures++;
      $display("FAIL rv32_clz result=%h we=%b required result=16 we=1", result, res_makes_rd);
    end
  endtask
  task automatic test_rotate();
    vec_t v[];
    v = '{'{{1'b1, OP_ROR}, 64'h1, 64'h1, 64'hFFFF_FFFF_8000_0000},
          '{{1'b0, OP_ROL}, 64'h8000_0000_0000_0000, 64'h1, 64'h1},
          '{{1'b0, OP_ROR}, 64'h1, 64'h4, 64'h1000_0000_0000_0000},
          '{{1'b0, OP_ROL}, 64'h8000_0000_0000_0000, 64'd65, 64'h1},
          '{{1'b1, OP_ROL}, 64'hAAAA_AAAA_4000_0000, 64'h1, 64'hFFFF_FFFF_8000_0000},
          '{{1'b1, OP_ROL}, 64'h0000_0000_4000_0001, 64'd34, 64'h0000_0000_0000_0005}};
    run_table("rotate", v);
  endtask
  task automatic test_logic();
    vec_t v[];
    v = '{'{{1'b0, OP_MIN}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF},
          '{{1'b0, OP_MINU}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1},
          '{{1'b0, OP_MAX}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1},
          '{{1'b1, OP_MAXU}, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF},
          '{{1'b0, OP_ANDN}, 64'hFF00, 64'h0F00, 64'hF000},
          '{{1'b0, OP_ORCB}, 64'h0001_0000_0080_0000, 64'h0, 64'h00FF_0000_00FF_0000},
          '{{1'b0, OP_REV8}, 64'h0102_0304_0506_0708, 64'h0, 64'h0807_0605_0403_0201},
          '{{1'b0, OP_RSVD}, 64'h1234, 64'h5678, 64'h0}};
    run_table("logic", v);
  endtask
  task automatic test_clmul();
    vec_t v[];
    logic ok;
    v = '{'{{1'b0, OP_CLMUL}, 64'h3, 64'h3, 64'h5},
          '{{1'b0, OP_CLMULH}, 64'h8000_0000_0000_0000, 64'h2, 64'h1},
          '{{1'b0, OP_CLMULR}, 64'h8000_0000_0000_0000, 64'h2, 64'h2},
          '{{1'b1, OP_CLMUL}, 64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000}};
    foreach (v[k]) begin
      drive(v[k].c, 5'd7, v[k].a, v[k].b);
      tick();
      enable = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (busy !== 1'b1 || res_makes_rd !== 1'b0) ok = 1'b0;
        tick();
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL clmul_busy[%0d] busy/we wrong during run, required busy=1 we=0 for 8 cycles", k);
      end
      checks++;
      if (busy !== 1'b0 || result !== v[k].e || res_makes_rd !== 1'b1 || res_rd !== 5'd7) begin
        failures++;
        $display("FAIL clmul[%0d] busy=%b result=%h we=%b rd=%0d required busy=0 result=%h we=1 rd=7",
                 k, busy, result, res_makes_rd, res_rd, v[k].e);
      end
      tick();
      checks++;
      if (res_makes_rd !== 1'b0) begin
        failures++;
        $display("FAIL clmul_pulse[%0d] we=%b required 0", k, res_makes_rd);
      end
    end
  endtask
  task automatic test_kill_run();
    drive({1'b0, OP_CLMUL}, 5'd9, 64'h3, 64'h3);
    tick();
    enable = 1'b0;
    tick();
    tick();
    commit_kill = 32'h1 << 9;
    tick();
    commit_kill = '0;
    checks++;
    if (busy !== 1'b0 || res_makes_rd !== 1'b0) begin
      failures++;
      $display("FAIL kill_run busy=%b we=%b required busy=0 we=0", busy, res_makes_rd);
    end
    drive({1'b0, OP_CLMUL}, 5'd9, 64'h2, 64'h3);
    tick();
    enable = 1'b0;
    repeat (8) tick();
    checks++;
    if (result !== 64'h6 || res_makes_rd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_kill result=%h we=%b busy=%b required result=6 we=1 busy=0", result, res_makes_rd, busy);
    end
    drive({1'b0, OP_CLMUL}, 5'd9, 64'h3, 64'h3);
    tick();
    enable = 1'b0;
    repeat (7) tick();
    commit_kill = 32'h1 << 9;
    tick();
    commit_kill = '0;
    checks++;
    if (res_makes_rd !== 1'b0 || busy !== 1'b0 || result !== 64'h6) begin
      failures++;
      $display("FAIL kill_last we=%b busy=%b result=%h required we=0 busy=0 result=6", res_makes_rd, busy, result);
    end
  endtask
  task automatic test_reset_mid();
    logic ok;
    drive({1'b0, OP_CLMUL}, 5'd2, 64'h3, 64'h3);
    tick();
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 64'h0 || res_rd !== 5'h0 || res_makes_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid busy=%b result=%h rd=%0d we=%b required all zero", busy, result, res_rd, res_makes_rd);
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (res_makes_rd !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_discard stale write-back or busy after reset, required none");
    end
  endtask
  task automatic test_kill_accept();
    commit_kill = 32'h1 << 4;
    drive({1'b0, OP_CLZ}, 5'd4, 64'h0F00, 64'h0);
    tick();
    checks++;
    if (res_makes_rd !== 1'b0 || busy !== 1'b0 || result !== 64'h0) begin
      failures++;
      $display("FAIL kill_accept we=%b busy=%b result=%h required we=0 busy=0 result=0", res_makes_rd, busy, result);
    end
    drive({1'b0, OP_CLMUL}, 5'd4, 64'h3, 64'h3);
    tick();
    enable = 1'b0;
    commit_kill = '0;
    checks++;
    if (busy !== 1'b0 || res_makes_rd !== 1'b0) begin
      failures++;
      $display("FAIL kill_accept_clmul busy=%b we=%b required busy=0 we=0", busy, res_makes_rd);
    end
    makes_rd = 1'b0;
    drive({1'b0, OP_CLZ}, 5'd4, 64'h0F00, 64'h0);
    tick();
    enable = 1'b0;
    makes_rd = 1'b1;
    checks++;
    if (res_makes_rd !== 1'b0 || result !== 64'h0) begin
      failures++;
      $display("FAIL no_makes_rd we=%b result=%h required we=0 result=0", res_makes_rd, result);
    end
  endtask
  task automatic test_back_to_back();
    drive({1'b0, OP_CLMUL}, 5'd5, 64'h3, 64'h3);
    tick();
    enable = 1'b0;
    repeat (8) tick();
    checks++;
    if (result !== 64'h5 || res_rd !== 5'd5 || res_makes_rd !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_clmul result=%h rd=%0d we=%b busy=%b required 5/5/1/0", result, res_rd, res_makes_rd, busy);
    end
    drive({1'b0, OP_MINU}, 5'd6, 64'h7, 64'h3);
    tick();
    enable = 1'b0;
    checks++;
    if (result !== 64'h3 || res_rd !== 5'd6 || res_makes_rd !== 1'b1) begin
      failures++;
      $display("FAIL b2b_minu result=%h rd=%0d we=%b required 3/6/1", result, res_rd, res_makes_rd);
    end
  endtask
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    control = '0;
    rd = '0;
    makes_rd = 1'b1;
    hart = '0;
    rv32 = 1'b0;
    r1 = '0;
    r2 = '0;
    commit_kill = '0;
    test_reset();
    test_count();
    test_rotate();
    test_logic();
    test_clmul();
    test_kill_run();
    test_reset_mid();
    test_kill_accept();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
